// File: rtl/wb_decode_mux_pkg.sv
// rtl/wb_decode_mux_pkg.sv - state encoding and elaboration helpers for the Wishbone decode mux
package wb_decode_mux_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) result++;
      return result;
   endfunction

endpackage

// File: rtl/wb_mux_timeout.sv
// rtl/wb_mux_timeout.sv - saturating wait counter that flags an unanswered external-ack access
module wb_mux_timeout
   import wb_decode_mux_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int CW = (TIMEOUT == 0) ? 1 : clog2(TIMEOUT + 1);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   // Holds at all-ones so a disabled timeout never wraps back to a match.
   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (en_i && (count_q != {CW{1'b1}})) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   generate
      if (TIMEOUT == 0) begin : g_off
         assign expired_o = 1'b0;
      end else begin : g_on
         assign expired_o = (count_q == CW'(TIMEOUT - 1));
      end
   endgenerate

endmodule

// File: rtl/wb_decode_mux.sv
// rtl/wb_decode_mux.sv - address-decoding Wishbone mux with internal/external ack and timeout
module wb_decode_mux
   import wb_decode_mux_pkg::*;
#(
   parameter int            NS      = 4,
   parameter int            SW      = 2,
   parameter logic [NS-1:0] ACK_INT = 4'b0110,
   parameter int            TIMEOUT = 255
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [31:0]      i_wb_cpu_adr,
   input  logic [31:0]      i_wb_cpu_dat,
   input  logic [3:0]       i_wb_cpu_sel,
   input  logic             i_wb_cpu_we,
   input  logic             i_wb_cpu_cyc,
   output logic [31:0]      o_wb_cpu_rdt,
   output logic             o_wb_cpu_ack,
   output logic             o_wb_cpu_err,
   output logic [31:0]      o_wb_s_adr,
   output logic [31:0]      o_wb_s_dat,
   output logic [3:0]       o_wb_s_sel,
   output logic             o_wb_s_we,
   output logic [NS-1:0]    o_wb_s_cyc,
   input  logic [NS*32-1:0] i_wb_s_rdt,
   input  logic [NS-1:0]    i_wb_s_ack
);

   state_t        state_q;
   logic [SW-1:0] idx_q;
   logic [31:0]   rdt_q;
   logic          ack_q;
   logic          err_q;

   logic [SW-1:0] cur_idx;
   logic          sel_hit;
   logic          sel_int;
   logic          sel_ack;
   logic [31:0]   sel_rdt;
   logic          expired;

   // The latched index keeps steering ack/rdt even if the CPU address moves mid-wait.
   assign cur_idx = (state_q == ST_WAIT) ? idx_q : i_wb_cpu_adr[31 -: SW];

   always_comb begin
      sel_hit = 1'b0;
      sel_int = 1'b0;
      sel_ack = 1'b0;
      sel_rdt = '0;
      for (int k = 0; k < NS; k++) begin
         if (cur_idx == SW'(k)) begin
            sel_hit = 1'b1;
            sel_int = ACK_INT[k];
            sel_ack = i_wb_s_ack[k];
            sel_rdt = i_wb_s_rdt[32*k +: 32];
         end
      end
   end

   always_comb begin
      o_wb_s_cyc = '0;
      for (int k = 0; k < NS; k++) begin
         o_wb_s_cyc[k] = i_wb_cpu_cyc && (cur_idx == SW'(k)) && (state_q != ST_RESP) && !i_rst;
      end
   end

   assign o_wb_s_adr   = i_wb_cpu_adr;
   assign o_wb_s_dat   = i_wb_cpu_dat;
   assign o_wb_s_sel   = i_wb_cpu_sel;
   assign o_wb_s_we    = i_wb_cpu_we;
   assign o_wb_cpu_rdt = rdt_q;
   assign o_wb_cpu_ack = ack_q;
   assign o_wb_cpu_err = err_q;

   wb_mux_timeout #(
      .TIMEOUT(TIMEOUT)
   ) u_timeout (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .clr_i    (state_q == ST_IDLE),
      .en_i     (state_q == ST_WAIT),
      .expired_o(expired)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         rdt_q   <= '0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         ack_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (i_wb_cpu_cyc) begin
                  idx_q <= cur_idx;
                  if (!sel_hit) begin
                     state_q <= ST_RESP;
                     ack_q   <= 1'b1;
                     err_q   <= 1'b1;
                     rdt_q   <= '0;
                  end else if (sel_int || sel_ack) begin
                     state_q <= ST_RESP;
                     ack_q   <= 1'b1;
                     err_q   <= 1'b0;
                     rdt_q   <= sel_rdt;
                  end else begin
                     state_q <= ST_WAIT;
                  end
               end
            end
            ST_WAIT: begin
               if (!i_wb_cpu_cyc) begin
                  state_q <= ST_IDLE;
               end else if (sel_ack) begin
                  state_q <= ST_RESP;
                  ack_q   <= 1'b1;
                  err_q   <= 1'b0;
                  rdt_q   <= sel_rdt;
               end else if (expired) begin
                  state_q <= ST_RESP;
                  ack_q   <= 1'b1;
                  err_q   <= 1'b1;
                  rdt_q   <= '0;
               end
            end
            ST_RESP: state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wb_decode_mux.sv
// tb/tb_wb_decode_mux.sv - randomized transaction-level bench for wb_decode_mux
module tb_wb_decode_mux;

   localparam int TO_A = 8;

   logic         clk;
   logic         rst;
   logic [31:0]  cpu_adr;
   logic [31:0]  cpu_dat;
   logic [3:0]   cpu_sel;
   logic         cpu_we;
   logic         cpu_cyc;

   logic [31:0]  a_rdt, a_s_adr, a_s_dat;
   logic         a_ack, a_err, a_s_we;
   logic [3:0]   a_s_sel;
   logic [3:0]   a_s_cyc;
   logic [127:0] a_s_rdt;
   logic [3:0]   a_s_ack;

   logic [31:0]  b_rdt, b_s_adr, b_s_dat;
   logic         b_ack, b_err, b_s_we;
   logic [3:0]   b_s_sel;
   logic [2:0]   b_s_cyc;
   logic [95:0]  b_s_rdt;
   logic [2:0]   b_s_ack;

   logic [3:0]   ack_int_a;
   logic [31:0]  hold_r;
   logic         hold_e;
   int           n_checks;
   int           n_errors;

   wb_decode_mux #(.NS(4), .SW(2), .ACK_INT(4'b0110), .TIMEOUT(TO_A)) u_dut_a (
      .i_clk(clk), .i_rst(rst),
      .i_wb_cpu_adr(cpu_adr), .i_wb_cpu_dat(cpu_dat), .i_wb_cpu_sel(cpu_sel),
      .i_wb_cpu_we(cpu_we), .i_wb_cpu_cyc(cpu_cyc),
      .o_wb_cpu_rdt(a_rdt), .o_wb_cpu_ack(a_ack), .o_wb_cpu_err(a_err),
      .o_wb_s_adr(a_s_adr), .o_wb_s_dat(a_s_dat), .o_wb_s_sel(a_s_sel), .o_wb_s_we(a_s_we),
      .o_wb_s_cyc(a_s_cyc), .i_wb_s_rdt(a_s_rdt), .i_wb_s_ack(a_s_ack)
   );

   wb_decode_mux #(.NS(3), .SW(2), .ACK_INT(3'b010), .TIMEOUT(0)) u_dut_b (
      .i_clk(clk), .i_rst(rst),
      .i_wb_cpu_adr(cpu_adr), .i_wb_cpu_dat(cpu_dat), .i_wb_cpu_sel(cpu_sel),
      .i_wb_cpu_we(cpu_we), .i_wb_cpu_cyc(cpu_cyc),
      .o_wb_cpu_rdt(b_rdt), .o_wb_cpu_ack(b_ack), .o_wb_cpu_err(b_err),
      .o_wb_s_adr(b_s_adr), .o_wb_s_dat(b_s_dat), .o_wb_s_sel(b_s_sel), .o_wb_s_we(b_s_we),
      .o_wb_s_cyc(b_s_cyc), .i_wb_s_rdt(b_s_rdt), .i_wb_s_ack(b_s_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Expected outcome is derived from the slave's ack delay alone: internal or
   // unmapped answers after one cycle, external answers one cycle after its ack,
   // and anything slower than TO_A cycles ends in an error response.
   task automatic a_txn(input logic [31:0] adr, input int d, input logic [31:0] val);
      int          idx;
      int          exp_c;
      logic        exp_e;
      logic [31:0] exp_r;
      idx = int'(adr[31:30]);
      if (ack_int_a[idx]) begin
         exp_c = 1; exp_e = 1'b0; exp_r = val;
      end else if (d >= 0 && d <= TO_A) begin
         exp_c = d + 1; exp_e = 1'b0; exp_r = val;
      end else begin
         exp_c = TO_A + 1; exp_e = 1'b1; exp_r = 32'd0;
      end
      for (int c = 0; c <= exp_c; c++) begin
         cpu_adr = adr;
         cpu_cyc = 1'b1;
         cpu_dat = $urandom;
         cpu_sel = 4'($urandom_range(0, 15));
         cpu_we  = 1'($urandom_range(0, 1));
         a_s_rdt = {$urandom, $urandom, $urandom, $urandom};
         a_s_rdt[idx*32 +: 32] = val;
         a_s_ack = 4'($urandom_range(0, 15)) & ~(4'(1) << idx);
         if (c == d) a_s_ack[idx] = 1'b1;
         #1;
         if (c == 0) begin
            check("bcast_adr", a_s_adr, adr);
            check("bcast_dat", a_s_dat, cpu_dat);
            check("bcast_sel", 32'(a_s_sel), 32'(cpu_sel));
            check("bcast_we", 32'(a_s_we), 32'(cpu_we));
         end
         if (c < exp_c) begin
            check("ack_early", 32'(a_ack), 32'd0);
            check("rdt_hold", a_rdt, hold_r);
            check("err_hold", 32'(a_err), 32'(hold_e));
            check("s_cyc_sel", 32'(a_s_cyc), 32'(4'(1) << idx));
         end else begin
            check("ack", 32'(a_ack), 32'd1);
            check("err", 32'(a_err), 32'(exp_e));
            check("rdt", a_rdt, exp_r);
            check("s_cyc_resp", 32'(a_s_cyc), 32'd0);
         end
         next_cycle();
      end
      hold_r = exp_r;
      hold_e = exp_e;
   endtask

   task automatic a_idle(input int n);
      for (int c = 0; c < n; c++) begin
         cpu_cyc = 1'b0;
         a_s_ack = 4'($urandom_range(0, 15));
         #1;
         check("idle_ack", 32'(a_ack), 32'd0);
         check("idle_s_cyc", 32'(a_s_cyc), 32'd0);
         check("idle_rdt", a_rdt, hold_r);
         next_cycle();
      end
   endtask

   task automatic a_abort(input int idx, input int w, input int late);
      logic [31:0] adr;
      adr = {2'(idx), 30'($urandom)};
      for (int c = 0; c < w + 4; c++) begin
         cpu_adr = adr;
         cpu_cyc = (c < w);
         a_s_ack = 4'($urandom_range(0, 15)) & ~(4'(1) << idx);
         if (c == w + late) a_s_ack[idx] = 1'b1;
         #1;
         check("abort_ack", 32'(a_ack), 32'd0);
         check("abort_rdt", a_rdt, hold_r);
         check("abort_err", 32'(a_err), 32'(hold_e));
         check("abort_s_cyc", 32'(a_s_cyc), (c < w) ? 32'(4'(1) << idx) : 32'd0);
         next_cycle();
      end
   endtask

   initial begin
      int          idx;
      int          d;
      logic [31:0] val;
      n_checks  = 0;
      n_errors  = 0;
      ack_int_a = 4'b0110;
      hold_r    = 32'd0;
      hold_e    = 1'b0;
      rst       = 1'b1;
      cpu_adr   = 32'h4000_0000;
      cpu_dat   = 32'd0;
      cpu_sel   = 4'hf;
      cpu_we    = 1'b0;
      cpu_cyc   = 1'b1;
      a_s_rdt   = '0;
      a_s_ack   = '0;
      b_s_rdt   = '0;
      b_s_ack   = '0;

      repeat (2) @(posedge clk);
      #1;
      check("rst_ack", 32'(a_ack), 32'd0);
      check("rst_err", 32'(a_err), 32'd0);
      check("rst_rdt", a_rdt, 32'd0);
      check("rst_s_cyc_a", 32'(a_s_cyc), 32'd0);
      check("rst_s_cyc_b", 32'(b_s_cyc), 32'd0);
      cpu_cyc = 1'b0;
      next_cycle();
      rst = 1'b0;
      a_idle(1);

      a_txn(32'h4000_0010, -1, 32'h1234_5678);
      a_idle(1);
      a_txn(32'h0000_0020, 3, 32'hCAFE_F00D);
      a_txn(32'hC000_0000, -1, 32'hDEAD_BEEF);
      a_txn(32'h8000_0004, -1, 32'h0BAD_CAFE);
      a_abort(0, 3, 1);
      a_txn(32'h0000_0000, 0, 32'h5555_AAAA);
      a_txn(32'hC000_0008, TO_A, 32'hA5A5_5A5A);

      for (int t = 0; t < 40; t++) begin
         if ($urandom_range(0, 9) == 0) begin
            a_abort(($urandom_range(0, 1) != 0) ? 3 : 0, $urandom_range(1, TO_A), $urandom_range(0, 2));
         end else begin
            idx = $urandom_range(0, 3);
            d   = $urandom_range(0, TO_A + 2);
            if (d == TO_A + 2) d = -1;
            val = $urandom;
            a_txn({2'(idx), 30'($urandom)}, d, val);
         end
         if ($urandom_range(0, 1) != 0) a_idle($urandom_range(1, 2));
      end

      for (int c = 0; c < 3; c++) begin
         cpu_adr = 32'h0000_0040;
         cpu_cyc = 1'b1;
         a_s_ack = 4'b0000;
         next_cycle();
      end
      rst = 1'b1;
      #1;
      check("rst_mid_s_cyc_a", 32'(a_s_cyc), 32'd0);
      check("rst_mid_s_cyc_b", 32'(b_s_cyc), 32'd0);
      next_cycle();
      rst     = 1'b0;
      cpu_cyc = 1'b0;
      for (int c = 0; c < 3; c++) begin
         a_s_ack = 4'b1111;
         #1;
         check("post_rst_ack", 32'(a_ack), 32'd0);
         check("post_rst_err", 32'(a_err), 32'd0);
         check("post_rst_rdt", a_rdt, 32'd0);
         next_cycle();
      end
      hold_r = 32'd0;
      hold_e = 1'b0;
      a_txn(32'h4000_0000, -1, 32'h600D_0001);
      a_txn(32'hC000_0000, 2, 32'h600D_0002);

      cpu_cyc = 1'b0;
      a_s_ack = '0;
      next_cycle();
      cpu_adr = 32'hC000_0000;
      cpu_cyc = 1'b1;
      #1;
      check("b_unmapped_s_cyc", 32'(b_s_cyc), 32'd0);
      next_cycle();
      check("b_unmapped_ack", 32'(b_ack), 32'd1);
      check("b_unmapped_err", 32'(b_err), 32'd1);
      check("b_unmapped_rdt", b_rdt, 32'd0);
      check("b_unmapped_s_cyc_resp", 32'(b_s_cyc), 32'd0);
      cpu_cyc = 1'b0;
      next_cycle();

      val = $urandom;
      cpu_adr = 32'h4000_0004;
      cpu_cyc = 1'b1;
      b_s_rdt = {$urandom, val, $urandom};
      #1;
      check("b_int_s_cyc", 32'(b_s_cyc), 32'b010);
      next_cycle();
      check("b_int_ack", 32'(b_ack), 32'd1);
      check("b_int_err", 32'(b_err), 32'd0);
      check("b_int_rdt", b_rdt, val);
      cpu_cyc = 1'b0;
      next_cycle();

      val = $urandom;
      for (int c = 0; c <= 21; c++) begin
         cpu_adr = 32'h0000_0000;
         cpu_cyc = 1'b1;
         b_s_rdt = {$urandom, $urandom, val};
         b_s_ack = (c == 20) ? 3'b001 : 3'b000;
         #1;
         if (c < 21) begin
            check("b_notimeout_ack_early", 32'(b_ack), 32'd0);
         end else begin
            check("b_notimeout_ack", 32'(b_ack), 32'd1);
            check("b_notimeout_err", 32'(b_err), 32'd0);
            check("b_notimeout_rdt", b_rdt, val);
         end
         next_cycle();
      end
      cpu_cyc = 1'b0;
      b_s_ack = '0;
      next_cycle();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
